// File: rtl/lvds_link_ctrl.sv
// lvds_link_ctrl: word alignment controller for an LVDS deserializer.
// After receiver lock it waits a settle period and then checks for a run of
// training words. On each mismatch it pulses rx_data_align (bit slip) and
// waits before checking again.
// Optional feature macro: LVDS_SLIP_LIMIT_EN. When it is defined, a slip
// budget of MAX_SLIPS applies and the FSM enters FAIL once the budget is
// exhausted. When it is undefined, slipping continues forever and link_err
// stays 0.
module lvds_link_ctrl #(
   parameter logic [9:0] TRAIN_PAT  = 10'h0F8,
   parameter int         SETTLE_CYC = 16,
   parameter int         MATCH_NUM  = 8,
   parameter int         SLIP_HOLD  = 2,
   parameter int         SLIP_WAIT  = 4,
   parameter int         MAX_SLIPS  = 10
) (
   input  logic       rx_clk,
   input  logic       rst,
   input  logic       rx_locked,
   input  logic [9:0] rx_data,
   input  logic       retrain,
   output logic       rx_data_align,
   output logic       align_done,
   output logic       link_err,
   output logic [3:0] slip_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SETTLE    = 3'd1,
      S_CHECK     = 3'd2,
      S_SLIP      = 3'd3,
      S_SLIP_WAIT = 3'd4,
      S_DONE      = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   state_t      cur_state;
   state_t      nxt_state;
   // One shared counter: settle timer, match count, slip pulse and slip wait timer.
   logic [15:0] cnt;
   logic [15:0] nxt_cnt;
   logic        nxt_align;
   logic        nxt_done;
   logic        nxt_err;
   logic [3:0]  nxt_slip;

   assign state = cur_state;

   // Next-state and next-output logic; all outputs are registered from these values.
   always_comb begin
      nxt_state = cur_state;
      nxt_cnt   = cnt;
      nxt_align = rx_data_align;
      nxt_done  = align_done;
      nxt_slip  = slip_cnt;
`ifdef LVDS_SLIP_LIMIT_EN
      nxt_err   = link_err;
`else
      nxt_err   = 1'b0;
`endif
      if ((cur_state != S_IDLE) && !rx_locked) begin
         // Loss of lock wins over everything except reset; slip count and error are kept.
         nxt_state = S_IDLE;
         nxt_cnt   = 16'd0;
         nxt_align = 1'b0;
         nxt_done  = 1'b0;
      end else if (retrain && ((cur_state == S_DONE) || (cur_state == S_FAIL))) begin
         nxt_state = S_SETTLE;
         nxt_cnt   = 16'd0;
         nxt_align = 1'b0;
         nxt_done  = 1'b0;
         nxt_err   = 1'b0;
         nxt_slip  = 4'd0;
      end else begin
         case (cur_state)
            S_IDLE: begin
               if (rx_locked) begin
                  nxt_state = S_SETTLE;
                  nxt_cnt   = 16'd0;
                  nxt_slip  = 4'd0;
                  nxt_align = 1'b0;
                  nxt_done  = 1'b0;
               end else begin
                  nxt_state = S_IDLE;
               end
            end
            S_SETTLE: begin
               if (cnt == 16'(SETTLE_CYC - 1)) begin
                  nxt_state = S_CHECK;
                  nxt_cnt   = 16'd0;
               end else begin
                  nxt_cnt   = cnt + 16'd1;
               end
            end
            S_CHECK: begin
               if (rx_data == TRAIN_PAT) begin
                  if (cnt == 16'(MATCH_NUM - 1)) begin
                     nxt_state = S_DONE;
                     nxt_done  = 1'b1;
                     nxt_cnt   = 16'd0;
                  end else begin
                     nxt_cnt   = cnt + 16'd1;
                  end
               end else begin
                  nxt_cnt = 16'd0;
`ifdef LVDS_SLIP_LIMIT_EN
                  if (slip_cnt == 4'(MAX_SLIPS)) begin
                     // Slip budget spent: give up without another pulse.
                     nxt_state = S_FAIL;
                     nxt_err   = 1'b1;
                     nxt_align = 1'b0;
                  end else begin
                     nxt_state = S_SLIP;
                     nxt_align = 1'b1;
                     nxt_slip  = slip_cnt + 4'd1;
                  end
`else
                  nxt_state = S_SLIP;
                  nxt_align = 1'b1;
                  nxt_slip  = slip_cnt + 4'd1;
`endif
               end
            end
            S_SLIP: begin
               if (cnt == 16'(SLIP_HOLD - 1)) begin
                  nxt_state = S_SLIP_WAIT;
                  nxt_align = 1'b0;
                  nxt_cnt   = 16'd0;
               end else begin
                  nxt_align = 1'b1;
                  nxt_cnt   = cnt + 16'd1;
               end
            end
            S_SLIP_WAIT: begin
               if (cnt == 16'(SLIP_WAIT - 1)) begin
                  nxt_state = S_CHECK;
                  nxt_cnt   = 16'd0;
               end else begin
                  nxt_cnt   = cnt + 16'd1;
               end
            end
            S_DONE: begin
               // Word content no longer matters once aligned.
               nxt_done = 1'b1;
            end
`ifdef LVDS_SLIP_LIMIT_EN
            S_FAIL: begin
               nxt_err = 1'b1;
            end
`endif
            default: begin
               // Unused encodings recover to IDLE.
               nxt_state = S_IDLE;
               nxt_cnt   = 16'd0;
               nxt_align = 1'b0;
               nxt_done  = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         cur_state     <= S_IDLE;
         cnt           <= 16'd0;
         rx_data_align <= 1'b0;
         align_done    <= 1'b0;
         link_err      <= 1'b0;
         slip_cnt      <= 4'd0;
      end else begin
         cur_state     <= nxt_state;
         cnt           <= nxt_cnt;
         rx_data_align <= nxt_align;
         align_done    <= nxt_done;
         link_err      <= nxt_err;
         slip_cnt      <= nxt_slip;
      end
   end

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Testbench for lvds_link_ctrl: random settle-time data, random receiver
// word rotations, lock loss, retrain, reset during a slip, and the slip
// budget (LVDS_SLIP_LIMIT_EN) or slip counter wrap (default build).
`timescale 1ns/1ps
module tb_lvds_link_ctrl;

   localparam logic [9:0] TRAIN_PAT  = 10'h0F8;
   localparam int         SETTLE_CYC = 16;
   localparam int         MATCH_NUM  = 8;
   localparam int         SLIP_HOLD  = 2;
   localparam int         SLIP_WAIT  = 4;
   localparam int         MAX_SLIPS  = 10;
   localparam int         SLIP_COST  = 1 + SLIP_HOLD + SLIP_WAIT;

   logic       rx_clk = 1'b0;
   logic       rst;
   logic       rx_locked;
   logic [9:0] rx_data;
   logic       retrain;
   logic       rx_data_align;
   logic       align_done;
   logic       link_err;
   logic [3:0] slip_cnt;
   logic [2:0] state;

   int checks = 0;
   int fails  = 0;
   int rot;
   logic prev_al;

   lvds_link_ctrl #(
      .TRAIN_PAT (TRAIN_PAT),
      .SETTLE_CYC(SETTLE_CYC),
      .MATCH_NUM (MATCH_NUM),
      .SLIP_HOLD (SLIP_HOLD),
      .SLIP_WAIT (SLIP_WAIT),
      .MAX_SLIPS (MAX_SLIPS)
   ) dut (
      .rx_clk       (rx_clk),
      .rst          (rst),
      .rx_locked    (rx_locked),
      .rx_data      (rx_data),
      .retrain      (retrain),
      .rx_data_align(rx_data_align),
      .align_done   (align_done),
      .link_err     (link_err),
      .slip_cnt     (slip_cnt),
      .state        (state)
   );

   always #5 rx_clk = ~rx_clk;

   function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
      logic [19:0] d;
      d = {v, v} << n;
      return d[19:10];
   endfunction

   // Expected {state, align, done, err, slip_cnt} after edge e of an alignment
   // attempt (edge 1 = lock first sampled high, or the retrain edge), where
   // the first r checks fail. Each failed check costs 1+SLIP_HOLD+SLIP_WAIT edges.
   function automatic logic [9:0] model(input int e, input int r);
      int st, sc, m, done_e;
      logic al, dn;
      done_e = 1 + SETTLE_CYC + MATCH_NUM + r * SLIP_COST;
      st = 2; sc = 0; al = 1'b0; dn = 1'b0;
      for (int k = 0; k < r; k++) begin
         m = SETTLE_CYC + 2 + k * SLIP_COST;
         if (m > e) break;
         sc++;
         if (e < m + SLIP_HOLD) begin
            st = 3; al = 1'b1;
         end else if (e < m + SLIP_HOLD + SLIP_WAIT) begin
            st = 4; al = 1'b0;
         end else begin
            st = 2; al = 1'b0;
         end
      end
      if (e <= SETTLE_CYC) begin
         st = 1;
      end else if (e >= done_e) begin
         st = 5; dn = 1'b1; al = 1'b0;
      end
      return {3'(st), al, dn, 1'b0, 4'(sc)};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {state, rx_data_align, align_done, link_err, slip_cnt};
   endfunction

   // Drives one alignment attempt up to edge last_e; the receiver model
   // presents the training word rotated by rot and unrotates by one bit per
   // rx_data_align pulse (zero_mode presents an all-zero word instead).
   task automatic run_align(input int r, input int last_e, input bit via_retrain, input bit zero_mode);
      int done_e;
      done_e  = 1 + SETTLE_CYC + MATCH_NUM + r * SLIP_COST;
      rot     = zero_mode ? 0 : r;
      prev_al = 1'b0;
      for (int e = 1; e <= last_e; e++) begin
         if (e == 1) begin
            if (via_retrain) retrain = 1'b1;
            else rx_locked = 1'b1;
         end else begin
            retrain = 1'b0;
         end
         if (e <= SETTLE_CYC + 1 || e > done_e) rx_data = 10'($urandom);
         else if (zero_mode) rx_data = 10'h000;
         else rx_data = rotl(TRAIN_PAT, rot);
         @(posedge rx_clk); #1;
         if (rx_data_align && !prev_al && rot > 0) rot--;
         prev_al = rx_data_align;
         check($sformatf("align r=%0d e=%0d", r, e), outs(), model(e, r));
      end
      retrain = 1'b0;
   endtask

   task automatic lock_drop(input int r);
      rx_locked = 1'b0;
      rx_data   = 10'($urandom);
      @(posedge rx_clk); #1;
      check("lock_drop", outs(), {3'd0, 1'b0, 1'b0, 1'b0, 4'(r % 16)});
   endtask

   initial begin
      int r;
      rst = 1'b1; rx_locked = 1'b0; retrain = 1'b0; rx_data = 10'h000;
      repeat (3) @(posedge rx_clk);
      #1;
      check("reset", outs(), 10'd0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         rx_data = 10'($urandom);
         @(posedge rx_clk); #1;
         check($sformatf("idle_nolock c=%0d", i), outs(), 10'd0);
      end

      // Clean link: aligned on edge 25 with no slips.
      run_align(0, 1 + SETTLE_CYC + MATCH_NUM + 2, 1'b0, 1'b0);
      // Retrain from DONE with a 3-bit rotated receiver.
      run_align(3, 1 + SETTLE_CYC + MATCH_NUM + 3 * SLIP_COST + 2, 1'b1, 1'b0);
      lock_drop(3);
      // Random rotations, each realigning after a one-cycle lock loss.
      for (int i = 0; i < 3; i++) begin
         r = $urandom_range(1, 6);
         run_align(r, 1 + SETTLE_CYC + MATCH_NUM + r * SLIP_COST + 2, 1'b0, 1'b0);
         lock_drop(r);
      end

      // Reset during the second SLIP cycle.
      run_align(2, SETTLE_CYC + 3, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge rx_clk); #1;
      check("rst_mid_slip", outs(), 10'd0);
      rst = 1'b0; rx_locked = 1'b0;
      @(posedge rx_clk); #1;
      check("after_rst_idle", outs(), 10'd0);

`ifdef LVDS_SLIP_LIMIT_EN
      // All-zero word: MAX_SLIPS pulses, then FAIL.
      run_align(999, SETTLE_CYC + 2 + MAX_SLIPS * SLIP_COST - 1, 1'b0, 1'b1);
      @(posedge rx_clk); #1;
      check("fail_entry", outs(), {3'd6, 1'b0, 1'b0, 1'b1, 4'(MAX_SLIPS)});
      repeat (5) @(posedge rx_clk);
      #1;
      check("fail_hold", outs(), {3'd6, 1'b0, 1'b0, 1'b1, 4'(MAX_SLIPS)});
      retrain = 1'b1;
      @(posedge rx_clk); #1;
      retrain = 1'b0;
      check("fail_retrain", outs(), {3'd1, 1'b0, 1'b0, 1'b0, 4'd0});
`else
      // All-zero word: slipping never stops and slip_cnt wraps past 15.
      run_align(999, SETTLE_CYC + 2 + 19 * SLIP_COST + 1, 1'b0, 1'b1);
      lock_drop(20);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
